// File: rtl/jtpang_vtiming_if.sv
// Video timing bundle: screen-flip and raster-interrupt controls going into
// the timing generator, pixel enables, counters, blanking/sync and interrupt
// lines coming out of it.
interface jtpang_vtiming_if #(
  parameter int HW   = 9,
  parameter int NIRQ = 2
);
  logic                 flip;
  logic [NIRQ*HW-1:0]   irq_line;
  logic [NIRQ-1:0]      irq_en;
  logic [NIRQ-1:0]      irq_ack;
  logic                 pxl2_cen;
  logic                 pxl_cen;
  logic [HW-1:0]        h;
  logic [HW-1:0]        v;
  logic [HW-1:0]        hf;
  logic [HW-1:0]        vf;
  logic                 LHBL;
  logic                 LVBL;
  logic                 HS;
  logic                 VS;
  logic [NIRQ-1:0]      irq_n;

  // Timing generator side
  modport master (
    input  flip, irq_line, irq_en, irq_ack,
    output pxl2_cen, pxl_cen, h, v, hf, vf, LHBL, LVBL, HS, VS, irq_n
  );

  // Consumer side (CPU, video pipeline)
  modport slave (
    output flip, irq_line, irq_en, irq_ack,
    input  pxl2_cen, pxl_cen, h, v, hf, vf, LHBL, LVBL, HS, VS, irq_n
  );
endinterface

// File: rtl/jtpang_vtiming.sv
// Raster timing generator: fractional pixel clock enables derived from the
// system clock, H/V counters, blanking and sync strobes, flipped counters and
// a set of independent raster-line interrupt channels.
module jtpang_vtiming #(
  parameter int HW       = 9,
  parameter int CEN_N    = 1,
  parameter int CEN_M    = 3,
  parameter int HCNT_END = 511,
  parameter int HB_START = 457,
  parameter int HB_END   = 73,
  parameter int HS_START = 495,
  parameter int HS_LEN   = 32,
  parameter int VCNT_END = 271,
  parameter int VB_START = 247,
  parameter int VB_END   = 7,
  parameter int VS_START = 263,
  parameter int VS_LEN   = 3,
  parameter int NIRQ     = 2
) (
  input  logic               clk,
  input  logic               rst,
  jtpang_vtiming_if.master   bus
);

  // Accumulator must hold r_acc + CEN_N with r_acc < CEN_M.
  localparam int AW = $clog2(CEN_M + CEN_N) + 1;

  localparam logic [AW-1:0] P_CEN_N = AW'(CEN_N);
  localparam logic [AW-1:0] P_CEN_M = AW'(CEN_M);

  // Sync end points wrap modulo the counter period.
  localparam int HS_END_I = (HS_START + HS_LEN) % (HCNT_END + 1);
  localparam int VS_END_I = (VS_START + VS_LEN) % (VCNT_END + 1);

  localparam logic [HW-1:0] P_HCNT_END = HW'(HCNT_END);
  localparam logic [HW-1:0] P_HB_START = HW'(HB_START);
  localparam logic [HW-1:0] P_HB_END   = HW'(HB_END);
  localparam logic [HW-1:0] P_HS_START = HW'(HS_START);
  localparam logic [HW-1:0] P_HS_END   = HW'(HS_END_I);
  localparam logic [HW-1:0] P_VCNT_END = HW'(VCNT_END);
  localparam logic [HW-1:0] P_VB_START = HW'(VB_START);
  localparam logic [HW-1:0] P_VB_END   = HW'(VB_END);
  localparam logic [HW-1:0] P_VS_START = HW'(VS_START);
  localparam logic [HW-1:0] P_VS_END   = HW'(VS_END_I);

  typedef enum logic {
    IRQ_IDLE = 1'b0,
    IRQ_PEND = 1'b1
  } irq_state_t;

  // Clock-enable generation
  logic [AW-1:0] r_acc;
  logic [AW-1:0] w_acc_sum;
  logic          w_acc_wrap;
  logic          r_pxl2_cen;
  logic          r_pxl_cen;
  logic          r_div;

  // Raster counters and strobes
  logic [HW-1:0] r_h;
  logic [HW-1:0] r_v;
  logic [HW-1:0] w_h_nxt;
  logic [HW-1:0] w_v_nxt;
  logic          w_h_wrap;
  logic          w_line_start;
  logic          r_lhbl;
  logic          r_hs;
  logic          r_lvbl;
  logic          r_vs;

  // Interrupt channels
  irq_state_t    r_st     [NIRQ];
  irq_state_t    w_st_nxt [NIRQ];
  logic [NIRQ-1:0] w_trig;
  logic [NIRQ-1:0] w_irq_n;

  assign w_acc_sum  = r_acc + P_CEN_N;
  assign w_acc_wrap = (w_acc_sum >= P_CEN_M);

  // Fractional divider: pxl2_cen on each accumulator wrap, pxl_cen on every other one
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_pxl2_cen <= 1'b0;
      r_pxl_cen  <= 1'b0;
      r_div      <= 1'b0;
    end else begin
      r_acc      <= w_acc_wrap ? (w_acc_sum - P_CEN_M) : w_acc_sum;
      r_pxl2_cen <= w_acc_wrap;
      r_pxl_cen  <= w_acc_wrap & r_div;
      if (w_acc_wrap) begin
        r_div <= ~r_div;
      end
    end
  end

  assign w_h_wrap     = (r_h == P_HCNT_END);
  assign w_h_nxt      = w_h_wrap ? '0 : (r_h + 1'b1);
  assign w_v_nxt      = (r_v == P_VCNT_END) ? '0 : (r_v + 1'b1);
  // The clock on which h rolls over and v advances to w_v_nxt.
  assign w_line_start = r_pxl_cen & w_h_wrap;

  // Horizontal counter and horizontal strobes, keyed on the value h is about to take
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h    <= '0;
      r_lhbl <= 1'b0;
      r_hs   <= 1'b0;
    end else if (r_pxl_cen) begin
      r_h <= w_h_nxt;
      if (w_h_nxt == P_HB_START) begin
        r_lhbl <= 1'b0;
      end else if (w_h_nxt == P_HB_END) begin
        r_lhbl <= 1'b1;
      end
      if (w_h_nxt == P_HS_START) begin
        r_hs <= 1'b1;
      end else if (w_h_nxt == P_HS_END) begin
        r_hs <= 1'b0;
      end
    end
  end

  // Vertical counter and vertical strobes, advanced only on the line wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v    <= '0;
      r_lvbl <= 1'b0;
      r_vs   <= 1'b0;
    end else if (w_line_start) begin
      r_v <= w_v_nxt;
      if (w_v_nxt == P_VB_START) begin
        r_lvbl <= 1'b0;
      end else if (w_v_nxt == P_VB_END) begin
        r_lvbl <= 1'b1;
      end
      if (w_v_nxt == P_VS_START) begin
        r_vs <= 1'b1;
      end else if (w_v_nxt == P_VS_END) begin
        r_vs <= 1'b0;
      end
    end
  end

  // Per-channel trigger: entering the programmed line; lines past the frame never match
  always_comb begin
    w_trig = '0;
    for (int k = 0; k < NIRQ; k++) begin
      w_trig[k] = w_line_start
                & bus.irq_en[k]
                & (bus.irq_line[k*HW +: HW] <= P_VCNT_END)
                & (w_v_nxt == bus.irq_line[k*HW +: HW]);
    end
  end

  // Interrupt channel state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NIRQ; k++) begin
        r_st[k] <= IRQ_IDLE;
      end
    end else begin
      for (int k = 0; k < NIRQ; k++) begin
        r_st[k] <= w_st_nxt[k];
      end
    end
  end

  // Interrupt channel next state; a trigger wins over a simultaneous ack
  always_comb begin
    w_irq_n = '1;
    for (int k = 0; k < NIRQ; k++) begin
      w_st_nxt[k] = r_st[k];
      case (r_st[k])
        IRQ_IDLE: begin
          if (w_trig[k]) begin
            w_st_nxt[k] = IRQ_PEND;
          end
        end
        IRQ_PEND: begin
          if (bus.irq_ack[k] && !w_trig[k]) begin
            w_st_nxt[k] = IRQ_IDLE;
          end
        end
        default: w_st_nxt[k] = IRQ_IDLE;
      endcase
      w_irq_n[k] = (r_st[k] != IRQ_PEND);
    end
  end

  assign bus.pxl2_cen = r_pxl2_cen;
  assign bus.pxl_cen  = r_pxl_cen;
  assign bus.h        = r_h;
  assign bus.v        = r_v;
  assign bus.hf       = r_h ^ {HW{bus.flip}};
  assign bus.vf       = r_v ^ {HW{bus.flip}};
  assign bus.LHBL     = r_lhbl;
  assign bus.LVBL     = r_lvbl;
  assign bus.HS       = r_hs;
  assign bus.VS       = r_vs;
  assign bus.irq_n    = w_irq_n;

endmodule

// File: tb/tb_jtpang_vtiming.sv
// Bench for jtpang_vtiming: one instance with the default 512x272 raster for
// clock-enable, horizontal and flip behaviour, and one with a shrunken
// 32x40 raster so frame wraps and raster interrupts are reached quickly.
module tb_jtpang_vtiming;

  logic clk   = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  jtpang_vtiming_if #(.HW(9), .NIRQ(2)) ia ();
  jtpang_vtiming_if #(.HW(9), .NIRQ(2)) ib ();

  jtpang_vtiming u_dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (ia)
  );

  jtpang_vtiming #(
    .HW(9), .CEN_N(1), .CEN_M(3),
    .HCNT_END(31), .HB_START(28), .HB_END(4), .HS_START(30), .HS_LEN(4),
    .VCNT_END(39), .VB_START(34), .VB_END(2), .VS_START(37), .VS_LEN(4),
    .NIRQ(2)
  ) u_dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (ib)
  );

  // Advance to the negedge just after the next pixel update of DUT A.
  task automatic step_a();
    int n;
    n = 0;
    while (ia.pxl_cen !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 20) begin
        n_cmp++; n_bad++;
        $display("FAIL step_a: no pxl_cen within %0d clks, required within 6", n);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "pixel enable stalled on DUT A");
      end
    end
    @(negedge clk);
  endtask

  task automatic step_b();
    int n;
    n = 0;
    while (ib.pxl_cen !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 20) begin
        n_cmp++; n_bad++;
        $display("FAIL step_b: no pxl_cen within %0d clks, required within 6", n);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "pixel enable stalled on DUT B");
      end
    end
    @(negedge clk);
  endtask

  task automatic reset_a();
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_a = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (ia.h !== 9'd0)       begin n_bad++; $display("FAIL rst_h: got %0d, expected 0", ia.h); end
    n_cmp++; if (ia.v !== 9'd0)       begin n_bad++; $display("FAIL rst_v: got %0d, expected 0", ia.v); end
    n_cmp++; if (ia.LHBL !== 1'b0)    begin n_bad++; $display("FAIL rst_lhbl: got %b, expected 0", ia.LHBL); end
    n_cmp++; if (ia.LVBL !== 1'b0)    begin n_bad++; $display("FAIL rst_lvbl: got %b, expected 0", ia.LVBL); end
    n_cmp++; if (ia.HS !== 1'b0)      begin n_bad++; $display("FAIL rst_hs: got %b, expected 0", ia.HS); end
    n_cmp++; if (ia.VS !== 1'b0)      begin n_bad++; $display("FAIL rst_vs: got %b, expected 0", ia.VS); end
    n_cmp++; if (ia.irq_n !== 2'b11)  begin n_bad++; $display("FAIL rst_irq_n: got %b, expected 11", ia.irq_n); end
    n_cmp++; if (ia.pxl_cen !== 1'b0) begin n_bad++; $display("FAIL rst_pxl_cen: got %b, expected 0", ia.pxl_cen); end
    n_cmp++; if (ia.pxl2_cen !== 1'b0) begin n_bad++; $display("FAIL rst_pxl2_cen: got %b, expected 0", ia.pxl2_cen); end
  endtask

  task automatic test_cen();
    int first2, e2, e1;
    first2 = -1; e2 = 0; e1 = 0;
    rst_a = 1'b0;
    for (int n = 1; n <= 36; n++) begin
      @(negedge clk);
      if (ia.pxl2_cen === 1'b1 && first2 < 0) first2 = n;
      if (ia.pxl2_cen !== (n % 3 == 0)) e2++;
      if (ia.pxl_cen  !== (n % 6 == 0)) e1++;
    end
    n_cmp++; if (first2 !== 3) begin n_bad++; $display("FAIL cen_first: first pxl2_cen at clk %0d, expected 3", first2); end
    n_cmp++; if (e2 !== 0) begin n_bad++; $display("FAIL cen_pxl2: %0d clks off the every-3 pattern, expected 0", e2); end
    n_cmp++; if (e1 !== 0) begin n_bad++; $display("FAIL cen_pxl: %0d clks off the every-6 pattern, expected 0", e1); end
    n_cmp++; if (ia.h !== 9'd5) begin n_bad++; $display("FAIL cen_h: got %0d after 36 clks, expected 5", ia.h); end
    n_cmp++; if (ia.v !== 9'd0) begin n_bad++; $display("FAIL cen_v: got %0d, expected 0", ia.v); end
  endtask

  task automatic test_hline();
    int ehv, el, es, nlow, nhs, t0, t1, hh;
    logic exp_l, exp_s;
    ehv = 0; el = 0; es = 0; nlow = 0; nhs = 0; t0 = 0; t1 = 0;
    reset_a();
    for (int k = 1; k <= 1024; k++) begin
      step_a();
      hh = k % 512;
      if (ia.h !== 9'(hh) || ia.v !== 9'(k / 512)) ehv++;
      if (k == 512)  t0 = cyc;
      if (k == 1024) t1 = cyc;
      if (k >= 512 && k < 1024) begin
        exp_l = !(hh >= 457 || hh < 73);
        exp_s = (hh >= 495 || hh < 15);
        if (ia.LHBL !== exp_l) el++;
        if (ia.HS !== exp_s) es++;
        if (ia.LHBL === 1'b0) nlow++;
        if (ia.HS === 1'b1) nhs++;
      end
    end
    n_cmp++; if (ehv !== 0)    begin n_bad++; $display("FAIL hline_hv: %0d pixels with wrong h/v, expected 0", ehv); end
    n_cmp++; if (el !== 0)     begin n_bad++; $display("FAIL hline_lhbl: %0d pixels with wrong LHBL, expected 0", el); end
    n_cmp++; if (es !== 0)     begin n_bad++; $display("FAIL hline_hs: %0d pixels with wrong HS, expected 0", es); end
    n_cmp++; if (nlow !== 128) begin n_bad++; $display("FAIL hline_blank_px: got %0d, expected 128", nlow); end
    n_cmp++; if (nhs !== 32)   begin n_bad++; $display("FAIL hline_sync_px: got %0d, expected 32", nhs); end
    n_cmp++; if (t1 - t0 !== 3072) begin n_bad++; $display("FAIL hline_clks: got %0d clks per line, expected 3072", t1 - t0); end
  endtask

  task automatic test_flip();
    int n;
    reset_a();
    n = 0;
    while (!(ia.v === 9'd5 && ia.h === 9'd10) && n < 3000) begin step_a(); n++; end
    n_cmp++; if (n >= 3000) begin n_bad++; $display("FAIL flip_seek: v=5 h=10 not reached, got v=%0d h=%0d", ia.v, ia.h); end
    n_cmp++; if (ia.hf !== 9'd10) begin n_bad++; $display("FAIL flip0_hf: got %0d, expected 10", ia.hf); end
    n_cmp++; if (ia.vf !== 9'd5)  begin n_bad++; $display("FAIL flip0_vf: got %0d, expected 5", ia.vf); end
    ia.flip = 1'b1;
    #1;
    n_cmp++; if (ia.hf !== 9'd501) begin n_bad++; $display("FAIL flip1_hf: got %0d, expected 501", ia.hf); end
    n_cmp++; if (ia.vf !== 9'd506) begin n_bad++; $display("FAIL flip1_vf: got %0d, expected 506", ia.vf); end
    ia.flip = 1'b0;
  endtask

  task automatic test_vertical();
    int ehv, elv, evs, mv;
    logic exp_lv, exp_vs;
    ehv = 0; elv = 0; evs = 0;
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (ib.irq_n !== 2'b11 || ib.LVBL !== 1'b0 || ib.v !== 9'd0)
      begin n_bad++; $display("FAIL rst_b: irq_n=%b LVBL=%b v=%0d, expected 11 0 0", ib.irq_n, ib.LVBL, ib.v); end
    rst_b = 1'b0;
    for (int k = 1; k <= 2560; k++) begin
      step_b();
      mv = (k / 32) % 40;
      if (ib.h !== 9'(k % 32) || ib.v !== 9'(mv)) ehv++;
      if (k >= 1280) begin
        exp_lv = !(mv >= 34 || mv < 2);
        exp_vs = (mv >= 37 || mv == 0);
        if (ib.LVBL !== exp_lv) elv++;
        if (ib.VS !== exp_vs) evs++;
      end
    end
    n_cmp++; if (ehv !== 0) begin n_bad++; $display("FAIL vert_hv: %0d pixels with wrong h/v, expected 0", ehv); end
    n_cmp++; if (elv !== 0) begin n_bad++; $display("FAIL vert_lvbl: %0d pixels with wrong LVBL, expected 0", elv); end
    n_cmp++; if (evs !== 0) begin n_bad++; $display("FAIL vert_vs: %0d pixels with wrong VS, expected 0", evs); end
  endtask

  task automatic seek_b(input int th, input int tv, input string tag);
    int n;
    n = 0;
    while (!(ib.h === 9'(th) && ib.v === 9'(tv)) && n < 2000) begin step_b(); n++; end
    n_cmp++; if (n >= 2000) begin n_bad++; $display("FAIL %s: h=%0d v=%0d not reached, got h=%0d v=%0d", tag, th, tv, ib.h, ib.v); end
  endtask

  task automatic test_irq_basic();
    ib.irq_line = {9'd0, 9'd10};
    ib.irq_en   = 2'b01;
    seek_b(31, 9, "irq_seek");
    n_cmp++; if (ib.irq_n !== 2'b11) begin n_bad++; $display("FAIL irq_before: got %b, expected 11", ib.irq_n); end
    step_b();
    n_cmp++; if (ib.irq_n !== 2'b10) begin n_bad++; $display("FAIL irq_trigger: got %b at v=%0d, expected 10", ib.irq_n, ib.v); end
    ib.irq_en = 2'b00;
    repeat (12) @(negedge clk);
    n_cmp++; if (ib.irq_n !== 2'b10) begin n_bad++; $display("FAIL irq_en_clear: got %b, expected 10", ib.irq_n); end
    ib.irq_ack = 2'b01;
    @(negedge clk);
    ib.irq_ack = 2'b00;
    n_cmp++; if (ib.irq_n !== 2'b11) begin n_bad++; $display("FAIL irq_ack: got %b, expected 11", ib.irq_n); end
  endtask

  task automatic test_back_to_back();
    int n1;
    ib.irq_line = {9'd300, 9'd10};
    ib.irq_en   = 2'b11;
    seek_b(31, 9, "coll_seek");
    ib.irq_ack = 2'b01;
    step_b();
    ib.irq_ack = 2'b00;
    n_cmp++; if (ib.irq_n[0] !== 1'b0) begin n_bad++; $display("FAIL coll_trigger: irq_n[0]=%b, expected 0", ib.irq_n[0]); end
    repeat (3) @(negedge clk);
    n_cmp++; if (ib.irq_n[0] !== 1'b0) begin n_bad++; $display("FAIL coll_hold: irq_n[0]=%b, expected 0", ib.irq_n[0]); end
    n1 = 0;
    for (int k = 0; k < 1280; k++) begin
      step_b();
      if (ib.irq_n[1] !== 1'b1) n1++;
    end
    n_cmp++; if (n1 !== 0) begin n_bad++; $display("FAIL irq_line300: irq_n[1] low on %0d pixels, expected 0", n1); end
    n_cmp++; if (ib.irq_n !== 2'b10) begin n_bad++; $display("FAIL coll_frame: got %b, expected 10", ib.irq_n); end
    ib.irq_ack = 2'b01;
    @(negedge clk);
    ib.irq_ack = 2'b00;
    n_cmp++; if (ib.irq_n !== 2'b11) begin n_bad++; $display("FAIL coll_ack: got %b, expected 11", ib.irq_n); end
  endtask

  task automatic test_equal_lines();
    ib.irq_line = {9'd20, 9'd20};
    ib.irq_en   = 2'b11;
    seek_b(31, 19, "eq_seek");
    n_cmp++; if (ib.irq_n !== 2'b11) begin n_bad++; $display("FAIL eq_before: got %b, expected 11", ib.irq_n); end
    step_b();
    n_cmp++; if (ib.irq_n !== 2'b00) begin n_bad++; $display("FAIL eq_trigger: got %b, expected 00", ib.irq_n); end
  endtask

  task automatic test_reset_mid();
    repeat (5) step_b();
    n_cmp++; if (ib.v !== 9'd20 || ib.h !== 9'd5 || ib.irq_n !== 2'b00)
      begin n_bad++; $display("FAIL mid_pre: v=%0d h=%0d irq_n=%b, expected 20 5 00", ib.v, ib.h, ib.irq_n); end
    rst_b = 1'b1;
    @(negedge clk);
    n_cmp++; if (ib.h !== 9'd0)      begin n_bad++; $display("FAIL mid_h: got %0d, expected 0", ib.h); end
    n_cmp++; if (ib.v !== 9'd0)      begin n_bad++; $display("FAIL mid_v: got %0d, expected 0", ib.v); end
    n_cmp++; if (ib.irq_n !== 2'b11) begin n_bad++; $display("FAIL mid_irq_n: got %b, expected 11", ib.irq_n); end
    n_cmp++; if (ib.LVBL !== 1'b0)   begin n_bad++; $display("FAIL mid_lvbl: got %b, expected 0", ib.LVBL); end
    n_cmp++; if (ib.LHBL !== 1'b0 || ib.HS !== 1'b0 || ib.VS !== 1'b0)
      begin n_bad++; $display("FAIL mid_strobes: LHBL=%b HS=%b VS=%b, expected 0 0 0", ib.LHBL, ib.HS, ib.VS); end
    n_cmp++; if (ib.pxl_cen !== 1'b0 || ib.pxl2_cen !== 1'b0)
      begin n_bad++; $display("FAIL mid_cen: pxl_cen=%b pxl2_cen=%b, expected 0 0", ib.pxl_cen, ib.pxl2_cen); end
    rst_b = 1'b0;
  endtask

  initial begin
    ia.flip = 1'b0; ia.irq_line = '0; ia.irq_en = '0; ia.irq_ack = '0;
    ib.flip = 1'b0; ib.irq_line = '0; ib.irq_en = '0; ib.irq_ack = '0;
    test_reset();
    test_cen();
    test_hline();
    test_flip();
    test_vertical();
    test_irq_basic();
    test_back_to_back();
    test_equal_lines();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jtpang_vtiming.md
JTPANG_VTIMING -- requirements
Module: jtpang_vtiming

Interface
REQ-001 Parameter HW, default 9: width of the H and V counters.
REQ-002 Parameter CEN_N, default 1: fractional clock-enable numerator.
REQ-003 Parameter CEN_M, default 3: fractional clock-enable denominator, CEN_M > CEN_N.
REQ-004 Parameters HCNT_END 511, HB_START 457, HB_END 73, HS_START 495, HS_LEN 32: horizontal timing in pixels.
REQ-005 Parameters VCNT_END 271, VB_START 247, VB_END 7, VS_START 263, VS_LEN 3: vertical timing in lines.
REQ-006 Parameter NIRQ, default 2, range 1-4: number of raster-interrupt channels.
REQ-007 clk  in  1: system clock (48 MHz); this is the block's only clock.
REQ-008 rst  in  1: reset; synchronous, active-high.
REQ-009 flip  in  1: screen flip.
REQ-010 irq_line  in  NIRQ*HW: per-channel target line; channel k uses bits [k*HW +: HW].
REQ-011 irq_en  in  NIRQ: per-channel enable.
REQ-012 irq_ack  in  NIRQ: per-channel acknowledge, one-clk pulse.
REQ-013 pxl2_cen / pxl_cen  out  1: double-rate and pixel clock enables.
REQ-014 h, v  out  HW: raw counters.
REQ-015 hf, vf  out  HW: h and v XOR {HW{flip}}.
REQ-016 LHBL, LVBL, HS, VS  out  1: blanking (active low) and sync (active high).
REQ-017 irq_n  out  NIRQ: per-channel interrupt, active low.

Function
REQ-018 pxl2_cen SHALL pulse for one clk at an average rate of CEN_N/CEN_M of clk, driven by a modulo-CEN_M accumulator; the first pulse SHALL occur CEN_M clks after rst release.
REQ-019 pxl_cen SHALL pulse on every second pxl2_cen, coincident with it, starting with the second pulse.
REQ-020 All counters and video outputs SHALL update only on cycles with pxl_cen=1.
REQ-021 h SHALL increment by 1 per pxl_cen and wrap HCNT_END->0.
REQ-022 On the h wrap, v SHALL increment, wrapping VCNT_END->0; v SHALL change on no other cycle.
REQ-023 LHBL SHALL go 0 on the pxl_cen where h becomes HB_START and go 1 where h becomes HB_END; HB_START > HB_END (wrapped window) SHALL be supported.
REQ-024 HS SHALL be 1 for exactly HS_LEN pixels starting where h becomes HS_START, wrapping modulo HCNT_END+1.
REQ-025 LVBL SHALL go 0 at the h wrap into line VB_START and go 1 at the h wrap into line VB_END.
REQ-026 VS SHALL go 1 at the h wrap into line VS_START and stay 1 for VS_LEN lines, wrapping modulo VCNT_END+1.
REQ-027 hf and vf SHALL be combinational from the registered h, v and flip.
REQ-028 Each channel SHALL be a two-state FSM, IDLE (irq_n=1) and PEND (irq_n=0).
REQ-029 IDLE->PEND SHALL occur at the h wrap into line irq_line[k] when irq_en[k]=1.
REQ-030 PEND->IDLE SHALL occur on the clk after irq_ack[k]=1.
REQ-031 A trigger and an ack on the same clk SHALL leave the channel in PEND.
REQ-032 Clearing irq_en[k] SHALL NOT clear a pending interrupt.
REQ-033 irq_line values above VCNT_END SHALL never trigger.
REQ-034 Channels SHALL be independent; equal irq_line values SHALL trigger all enabled matching channels on the same clk.

Reset
REQ-035 While rst=1: h=0, v=0, LHBL=0, LVBL=0, HS=0, VS=0, irq_n all 1, pxl_cen=pxl2_cen=0, accumulator and divider cleared.
REQ-036 rst asserted mid-frame SHALL return all state to REQ-035 values on the next clk with no extra sync pulse.

Verification
REQ-037 Defaults, run 2 frames -> pxl2_cen every 3 clks, pxl_cen every 6 clks; line = 512 pxl_cen; frame = 272 lines.
REQ-038 Defaults -> LHBL low for h 457..511 and 0..72 (128 px per line); HS high for h 495..511 and 0..14; LVBL low for lines 247..6; VS high for lines 263..265.
REQ-039 irq_line[0]=100, irq_en=01 -> irq_n[0] falls at the h wrap into v=100; irq_n[1] stays 1; irq_ack[0] pulse -> irq_n[0]=1 on the next clk.
REQ-040 Hold irq_ack[0]=1 across the trigger clk for line 100 -> irq_n[0]=0 afterwards; irq_line[1]=300 with irq_en[1]=1 -> irq_n[1] never falls.
REQ-041 flip=1 at v=5, h=10 -> vf=506, hf=501 in the same cycle.
REQ-042 rst=1 for 1 clk at v=150 with irq_n[0]=0 -> next clk: h=0, v=0, irq_n=all 1, LVBL=0.
